// File: rtl/chroma_ds_pkg.sv
// Shared constants for the chroma downsampler: output modes, FSM encoding and
// adder-width helpers used to size the horizontal and vertical chroma sums.
package chroma_ds_pkg;

    localparam logic [1:0] MODE_444 = 2'd0;
    localparam logic [1:0] MODE_422 = 2'd1;
    localparam logic [1:0] MODE_420 = 2'd2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    // Sum of two components needs one extra bit, sum of four needs two.
    function automatic int hsum_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int vsum_w(input int data_w);
        return data_w + 2;
    endfunction

    // Mode 3 is reserved and behaves as pass-through 4:4:4.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_444 : m;
    endfunction

endpackage

// File: rtl/chroma_downsampler_param_if.sv
// Pixel stream bundle for the chroma downsampler: upstream beat, downstream
// beat, frame mode select and the format-error pulse.
interface chroma_downsampler_param_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        mode;
    logic              s_valid;
    logic              s_ready;
    logic              s_sof;
    logic              s_eol;
    logic [DATA_W-1:0] s_y;
    logic [DATA_W-1:0] s_cb;
    logic [DATA_W-1:0] s_cr;
    logic              m_valid;
    logic              m_ready;
    logic              m_sof;
    logic              m_eol;
    logic [DATA_W-1:0] m_y;
    logic              m_c_valid;
    logic [DATA_W-1:0] m_cb;
    logic [DATA_W-1:0] m_cr;
    logic              err_fmt;

    modport master (
        output mode, s_valid, s_sof, s_eol, s_y, s_cb, s_cr, m_ready,
        input  s_ready, m_valid, m_sof, m_eol, m_y, m_c_valid, m_cb, m_cr, err_fmt
    );

    modport slave (
        input  mode, s_valid, s_sof, s_eol, s_y, s_cb, s_cr, m_ready,
        output s_ready, m_valid, m_sof, m_eol, m_y, m_c_valid, m_cb, m_cr, err_fmt
    );
endinterface

// File: rtl/chroma_line_buf.sv
// Line buffer holding the horizontal Cb/Cr pair sums of the previous even row;
// one write port and one synchronous read port whose data holds until the next read.
module chroma_line_buf
    import chroma_ds_pkg::*;
#(
    parameter int DEPTH  = 320,
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 2 * hsum_w(8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the storage array is deliberately left out of reset so it maps onto
    // RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/chroma_downsampler_param.sv
// Streaming YCbCr chroma downsampler (4:4:4 / 4:2:2 / 4:2:0), 1-cycle latency.
// Define CHROMA_ROUND_EN for round-half-up averaging; truncation otherwise.
module chroma_downsampler_param
    import chroma_ds_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640,
    parameter int ADDR_W = $clog2(LINE_W / 2)
) (
    input logic                  Clock,
    input logic                  Reset_n,
    chroma_downsampler_param_if.slave bus
);

    localparam int HW = hsum_w(DATA_W);
    localparam int VW = vsum_w(DATA_W);
    localparam int XW = $clog2(LINE_W);
`ifdef CHROMA_ROUND_EN
    localparam int RND_H = 1;
    localparam int RND_V = 2;
`else
    localparam int RND_H = 0;
    localparam int RND_V = 0;
`endif

    logic [0:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d, mode_cur;
    logic [XW-1:0]     x_q, x_d, x_cur;
    logic              row_q, row_d, row_cur;
    logic [DATA_W-1:0] cb_even_q, cr_even_q;

    logic              m_valid_q, m_sof_q, m_eol_q, m_c_valid_q, err_fmt_q;
    logic [DATA_W-1:0] m_y_q, m_cb_q, m_cr_q;

    logic              s_ready, accept, proc;
    logic              odd_x, at_max, line_end, fmt_err;
    logic              wr_en, rd_en;
    logic [HW-1:0]     hsum_cb, hsum_cr, buf_cb, buf_cr;
    logic [2*HW-1:0]   rd_data;
    logic              c_valid_d;
    logic [DATA_W-1:0] cb_d, cr_d;

    assign s_ready = !m_valid_q || bus.m_ready;
    assign accept  = bus.s_valid && s_ready;
    // Beats arriving before the first start-of-frame are swallowed.
    assign proc    = accept && (state_q == ACTIVE || bus.s_sof);

    // A start-of-frame beat is always column 0 of row 0 in the newly selected mode.
    assign x_cur    = bus.s_sof ? '0 : x_q;
    assign row_cur  = bus.s_sof ? 1'b0 : row_q;
    assign mode_cur = bus.s_sof ? norm_mode(bus.mode) : mode_q;

    assign odd_x    = x_cur[0];
    assign at_max   = (x_cur == XW'(LINE_W - 1));
    assign line_end = bus.s_eol || at_max;
    assign fmt_err  = (bus.s_eol && !odd_x) || (at_max && !bus.s_eol);

    assign hsum_cb = HW'(cb_even_q) + HW'(bus.s_cb);
    assign hsum_cr = HW'(cr_even_q) + HW'(bus.s_cr);
    assign {buf_cb, buf_cr} = rd_data;

    assign wr_en = proc && (mode_cur == MODE_420) && !row_cur && odd_x;
    assign rd_en = proc && (mode_cur == MODE_420) && row_cur && !odd_x;

    chroma_line_buf #(
        .DEPTH  (LINE_W / 2),
        .ADDR_W (ADDR_W),
        .WIDTH  (2 * HW)
    ) u_line_buf (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (ADDR_W'(x_cur >> 1)),
        .wr_data_i ({hsum_cb, hsum_cr}),
        .rd_en_i   (rd_en),
        .rd_addr_i (ADDR_W'(x_cur >> 1)),
        .rd_data_o (rd_data)
    );

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        c_valid_d = 1'b0;
        cb_d      = '0;
        cr_d      = '0;
        case (mode_cur)
            MODE_422: begin
                if (odd_x) begin
                    c_valid_d = 1'b1;
                    cb_d      = DATA_W'((hsum_cb + HW'(RND_H)) >> 1);
                    cr_d      = DATA_W'((hsum_cr + HW'(RND_H)) >> 1);
                end
            end
            MODE_420: begin
                if (odd_x && row_cur) begin
                    c_valid_d = 1'b1;
                    cb_d      = DATA_W'((VW'(hsum_cb) + VW'(buf_cb) + VW'(RND_V)) >> 2);
                    cr_d      = DATA_W'((VW'(hsum_cr) + VW'(buf_cr) + VW'(RND_V)) >> 2);
                end
            end
            default: begin
                c_valid_d = 1'b1;
                cb_d      = bus.s_cb;
                cr_d      = bus.s_cr;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        row_d   = row_q;
        if (proc) begin
            state_d = ACTIVE;
            mode_d  = mode_cur;
            if (line_end) begin
                x_d   = '0;
                row_d = !row_cur;
            end else begin
                x_d   = x_cur + XW'(1);
                row_d = row_cur;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_444;
            x_q         <= '0;
            row_q       <= 1'b0;
            cb_even_q   <= '0;
            cr_even_q   <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            m_c_valid_q <= 1'b0;
            m_y_q       <= '0;
            m_cb_q      <= '0;
            m_cr_q      <= '0;
            err_fmt_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            x_q       <= x_d;
            row_q     <= row_d;
            err_fmt_q <= proc && fmt_err;
            if (proc && !odd_x) begin
                cb_even_q <= bus.s_cb;
                cr_even_q <= bus.s_cr;
            end
            if (proc) begin
                m_valid_q   <= 1'b1;
                m_sof_q     <= bus.s_sof;
                m_eol_q     <= bus.s_eol;
                m_y_q       <= bus.s_y;
                m_c_valid_q <= c_valid_d;
                m_cb_q      <= cb_d;
                m_cr_q      <= cr_d;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_sof     = m_sof_q;
    assign bus.m_eol     = m_eol_q;
    assign bus.m_y       = m_y_q;
    assign bus.m_c_valid = m_c_valid_q;
    assign bus.m_cb      = m_cb_q;
    assign bus.m_cr      = m_cr_q;
    assign bus.err_fmt   = err_fmt_q;

endmodule

// File: tb/tb_chroma_downsampler_param.sv
// Scoreboard bench for chroma_downsampler_param: a behavioural model queues the
// expected output beat at every accepted input; a monitor pops and compares.
`timescale 1ns/1ps
module tb_chroma_downsampler_param;

    localparam int DATA_W = 8;
    localparam int LINE_W = 8;
`ifdef CHROMA_ROUND_EN
    localparam int RND_H = 1;
    localparam int RND_V = 2;
`else
    localparam int RND_H = 0;
    localparam int RND_V = 0;
`endif

    typedef struct {
        int y;
        int sof;
        int eol;
        int cv;
        int cb;
        int cr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chroma_downsampler_param_if #(.DATA_W(DATA_W)) bus ();

    chroma_downsampler_param #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   err_exp = 0;
    int   err_obs = 0;
    int   beats_seen = 0;

    // Reference model state
    int act = 0, md = 0, xm = 0, rowm = 0, pcb = 0, pcr = 0;
    int lb_cb [LINE_W/2];
    int lb_cr [LINE_W/2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input int y, input int cb, input int cr, input bit sof, input bit eol);
        exp_t e;
        bit   odd, at_max;
        int   hcb, hcr;
        if (!act && !sof) return;
        if (sof) begin
            act  = 1;
            md   = (int'(bus.mode) == 3) ? 0 : int'(bus.mode);
            xm   = 0;
            rowm = 0;
        end
        odd    = (xm % 2) == 1;
        at_max = (xm == LINE_W - 1);
        if ((eol && !odd) || (at_max && !eol)) err_exp++;
        e.y = y; e.sof = sof; e.eol = eol; e.cv = 0; e.cb = 0; e.cr = 0;
        hcb = pcb + cb;
        hcr = pcr + cr;
        if (md == 1 || md == 2) begin
            if (!odd) begin
                pcb = cb;
                pcr = cr;
            end else if (md == 1) begin
                e.cv = 1;
                e.cb = (hcb + RND_H) / 2;
                e.cr = (hcr + RND_H) / 2;
            end else if (rowm == 0) begin
                lb_cb[xm/2] = hcb;
                lb_cr[xm/2] = hcr;
            end else begin
                e.cv = 1;
                e.cb = (hcb + lb_cb[xm/2] + RND_V) / 4;
                e.cr = (hcr + lb_cr[xm/2] + RND_V) / 4;
            end
        end else begin
            e.cv = 1;
            e.cb = cb;
            e.cr = cr;
        end
        sb.push_back(e);
        if (eol || at_max) begin
            xm   = 0;
            rowm = 1 - rowm;
        end else begin
            xm++;
        end
    endtask

    task automatic send(input int y, input int cb, input int cr, input bit sof, input bit eol);
        int n   = 0;
        bit acc = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_y     = DATA_W'(y);
        bus.s_cb    = DATA_W'(cb);
        bus.s_cr    = DATA_W'(cr);
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            n++;
        end
        check("accept_in_time", 32'(acc), 1);
        if (acc) model_accept(y, cb, cr, sof, eol);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_drained"}, 32'(sb.size()), 0);
        check({tag, "_err_cnt"}, 32'(err_obs), 32'(err_exp));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.err_fmt) err_obs++;
            if (rst_n && bus.m_valid && bus.m_ready) begin
                beats_seen++;
                check("sb_has_entry", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("m_y", 32'(bus.m_y), 32'(e.y));
                    check("m_sof", 32'(bus.m_sof), 32'(e.sof));
                    check("m_eol", 32'(bus.m_eol), 32'(e.eol));
                    check("m_c_valid", 32'(bus.m_c_valid), 32'(e.cv));
                    if (e.cv != 0) begin
                        check("m_cb", 32'(bus.m_cb), 32'(e.cb));
                        check("m_cr", 32'(bus.m_cr), 32'(e.cr));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [DATA_W-1:0] hold_y, hold_cb;
        int                seen_before;

        bus.mode    = 2'd0;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        bus.s_y     = '0;
        bus.s_cb    = '0;
        bus.s_cr    = '0;
        bus.m_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_m_sof", 32'(bus.m_sof), 0);
        check("rst_m_eol", 32'(bus.m_eol), 0);
        check("rst_m_c_valid", 32'(bus.m_c_valid), 0);
        check("rst_err_fmt", 32'(bus.err_fmt), 0);
        check("rst_m_y", 32'(bus.m_y), 0);
        check("rst_m_cb", 32'(bus.m_cb), 0);
        check("rst_m_cr", 32'(bus.m_cr), 0);
        check("rst_s_ready", 32'(bus.s_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4:4:4 line, with a one-cycle latency check on the first beat
        bus.mode = 2'd0;
        send(1, 10, 50, 1, 0);
        check("latency_444", 32'(bus.m_valid), 1);
        send(2, 20, 60, 0, 0);
        send(3, 30, 70, 0, 0);
        send(4, 40, 80, 0, 1);
        drain("t444");

        // 4:2:2: pair 10,13 then 100,201
        bus.mode = 2'd1;
        send(5, 10, 30, 1, 0);
        send(6, 13, 33, 0, 0);
        send(7, 100, 0, 0, 0);
        send(8, 201, 255, 0, 1);
        drain("t422");

        // 4:2:0: row0 10,12 / 20,22 then row1 14,16 / 24,26
        bus.mode = 2'd2;
        send(9, 10, 40, 1, 0);
        send(10, 12, 41, 0, 0);
        send(11, 20, 90, 0, 0);
        send(12, 22, 91, 0, 1);
        send(13, 14, 42, 0, 0);
        send(14, 16, 44, 0, 0);
        send(15, 24, 92, 0, 0);
        send(16, 26, 95, 0, 1);
        drain("t420");

        // Backpressure: m_ready low mid-line
        bus.mode = 2'd1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(100 + i, 10 * i + 5, 200 - 7 * i, i == 0, i == 7);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.m_ready = 1'b0;
                @(negedge clk);
                hold_y  = bus.m_y;
                hold_cb = bus.m_cb;
                check("stall_m_valid", 32'(bus.m_valid), 1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_s_ready", 32'(bus.s_ready), 0);
                    check("stall_m_y", 32'(bus.m_y), 32'(hold_y));
                    check("stall_m_cb", 32'(bus.m_cb), 32'(hold_cb));
                end
                @(posedge clk);
                #1 bus.m_ready = 1'b1;
            end
        join
        drain("stall");

        // 4:2:2 odd-length line, next line must restart at x=0
        bus.mode = 2'd1;
        send(20, 10, 10, 1, 0);
        send(21, 13, 13, 0, 0);
        send(22, 77, 77, 0, 1);
        send(23, 20, 40, 0, 0);
        send(24, 30, 50, 0, 1);
        drain("odd_line");
        check("odd_line_err", 32'(err_obs), 1);

        // Line overrun: no eol within LINE_W pixels
        bus.mode = 2'd1;
        for (int i = 0; i < LINE_W; i++) send(30 + i, 3 * i, 255 - 3 * i, i == 0, 0);
        send(40, 50, 60, 0, 0);
        send(41, 51, 61, 0, 1);
        drain("overrun");

        // Reserved mode 3 behaves as 4:4:4
        bus.mode = 2'd3;
        send(50, 7, 8, 1, 0);
        send(51, 9, 10, 0, 1);
        drain("mode3");

        // Random 4:2:0 frames, with a mid-frame mode change that must be ignored
        for (int f = 0; f < 3; f++) begin
            bus.mode = 2'd2;
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < LINE_W; i++) begin
                    if (r == 1 && i == 3) bus.mode = 2'd0;
                    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                         r == 0 && i == 0, i == LINE_W - 1);
                end
            end
        end
        drain("rand420");

        // Reset mid-line in 4:2:0 with an output beat in flight
        bus.mode = 2'd2;
        send(60, 11, 12, 1, 0);
        send(61, 13, 14, 0, 0);
        send(62, 15, 16, 0, 0);
        bus.m_ready = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        act = 0; xm = 0; rowm = 0; md = 0;
        @(negedge clk);
        check("rst_mid_m_valid", 32'(bus.m_valid), 0);
        check("rst_mid_m_c_valid", 32'(bus.m_c_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        seen_before = beats_seen;
        send(63, 1, 2, 0, 0);
        send(64, 3, 4, 0, 0);
        send(65, 5, 6, 0, 1);
        drain("post_rst_drop");
        check("post_rst_no_beats", 32'(beats_seen), 32'(seen_before));
        bus.mode = 2'd2;
        send(70, 10, 20, 1, 0);
        send(71, 12, 22, 0, 1);
        send(72, 14, 24, 0, 0);
        send(73, 16, 26, 0, 1);
        drain("post_rst_420");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
